// File: rtl/midi_msg_sequencer_if.sv
// rtl/midi_msg_sequencer_if.sv - byte input and event output bundle for midi_msg_sequencer
interface midi_msg_sequencer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_type;
  logic [3:0] evt_ch;
  logic [6:0] evt_d1;
  logic [6:0] evt_d2;
  logic       evt_ovf;

  modport master (
    input  byte_in, byte_valid, evt_ready,
    output evt_valid, evt_type, evt_ch, evt_d1, evt_d2, evt_ovf
  );

  modport slave (
    output byte_in, byte_valid, evt_ready,
    input  evt_valid, evt_type, evt_ch, evt_d1, evt_d2, evt_ovf
  );
endinterface

// File: rtl/midi_msg_sequencer.sv
// rtl/midi_msg_sequencer.sv - MIDI running-status sequencer; MIDI_OMNI_EN bypasses the channel filter
module midi_msg_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 480000,
  parameter int          TO_W        = 20
) (
  input  logic                    reg_clk,
  input  logic                    reset,
  input  logic [3:0]              cur_midi_ch,
  output logic [7:0]              cur_status,
  midi_msg_sequencer_if.master    bus
);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2, SYSEX} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state, state_n;
  logic [7:0]      status_n;
  logic            rs_valid, rs_n;
  logic [6:0]      d1_q, d1_n;
  logic [TO_W-1:0] to_cnt;

  logic            is_rt, nb, in_data, to_hit, two_byte;
  logic            cmp, ch_ok, type_ok, emit;
  logic [6:0]      cmp_d1, cmp_d2;
  logic [2:0]      cmp_type;

`ifdef MIDI_OMNI_EN
  logic unused_ch;
  assign unused_ch = ^cur_midi_ch;
  assign ch_ok = 1'b1;
`else
  assign ch_ok = (cur_status[3:0] == cur_midi_ch);
`endif

  // Byte classification, next-state parsing and completed-message decode
  always_comb begin
    state_n  = state;
    status_n = cur_status;
    rs_n     = rs_valid;
    d1_n     = d1_q;
    cmp      = 1'b0;
    cmp_d1   = 7'd0;
    cmp_d2   = 7'd0;
    cmp_type = 3'd0;
    type_ok  = 1'b0;

    // Realtime bytes are invisible to the parser and the timer
    is_rt    = bus.byte_valid && (bus.byte_in[7:3] == 5'b11111);
    nb       = bus.byte_valid && !is_rt;
    in_data  = (state == DATA1) || (state == DATA2);
    to_hit   = (TIMEOUT_CYC != 0) && in_data && !nb && (to_cnt == TO_LAST);
    // Cx (program) and Dx (channel pressure) carry a single data byte
    two_byte = (cur_status[7:5] != 3'b110);

    if (to_hit) begin
      state_n = IDLE;
    end else if (nb) begin
      if (bus.byte_in[7]) begin
        if (bus.byte_in < 8'hF0) begin
          status_n = bus.byte_in;
          rs_n     = 1'b1;
          state_n  = DATA1;
        end else if (bus.byte_in == 8'hF0) begin
          rs_n    = 1'b0;
          state_n = SYSEX;
        end else begin
          // F1-F7: also terminates or aborts a sysex
          rs_n    = 1'b0;
          state_n = IDLE;
        end
      end else begin
        case (state)
          IDLE, DATA1: begin
            if (rs_valid) begin
              if (two_byte) begin
                d1_n    = bus.byte_in[6:0];
                state_n = DATA2;
              end else begin
                cmp     = 1'b1;
                cmp_d1  = bus.byte_in[6:0];
                state_n = IDLE;
              end
            end
          end
          DATA2: begin
            cmp     = 1'b1;
            cmp_d1  = d1_q;
            cmp_d2  = bus.byte_in[6:0];
            state_n = IDLE;
          end
          default: ;
        endcase
      end
    end

    case (cur_status[7:4])
      4'h8: begin cmp_type = 3'd0; type_ok = 1'b1; end
      4'h9: begin cmp_type = (cmp_d2 == 7'd0) ? 3'd0 : 3'd1; type_ok = 1'b1; end
      4'hB: begin cmp_type = 3'd2; type_ok = 1'b1; end
      4'hC: begin cmp_type = 3'd3; type_ok = 1'b1; end
      4'hE: begin cmp_type = 3'd4; type_ok = 1'b1; end
      default: begin cmp_type = 3'd0; type_ok = 1'b0; end
    endcase

    emit = cmp && ch_ok && type_ok;
  end

  // Parser state, running status and pending first data byte
  always_ff @(posedge reg_clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_status <= 8'd0;
      rs_valid   <= 1'b0;
      d1_q       <= 7'd0;
    end else begin
      state      <= state_n;
      cur_status <= status_n;
      rs_valid   <= rs_n;
      d1_q       <= d1_n;
    end
  end

  // Inter-byte idle timer, only running while a message is partially received
  always_ff @(posedge reg_clk) begin
    if (reset || nb || !in_data || to_hit) begin
      to_cnt <= '0;
    end else if (TIMEOUT_CYC != 0) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Event output register: load when free or being drained, flag overflow otherwise
  always_ff @(posedge reg_clk) begin
    if (reset) begin
      bus.evt_valid <= 1'b0;
      bus.evt_type  <= 3'd0;
      bus.evt_ch    <= 4'd0;
      bus.evt_d1    <= 7'd0;
      bus.evt_d2    <= 7'd0;
      bus.evt_ovf   <= 1'b0;
    end else begin
      bus.evt_ovf <= 1'b0;
      if (emit) begin
        if (!bus.evt_valid || bus.evt_ready) begin
          bus.evt_valid <= 1'b1;
          bus.evt_type  <= cmp_type;
          bus.evt_ch    <= cur_status[3:0];
          bus.evt_d1    <= cmp_d1;
          bus.evt_d2    <= cmp_d2;
        end else begin
          bus.evt_ovf <= 1'b1;
        end
      end else if (bus.evt_ready) begin
        bus.evt_valid <= 1'b0;
      end
    end
  end

endmodule
